// File: rtl/input_conditioner.sv
// Input conditioner: 2-flop synchronizer followed by a debounce FSM that
// accepts a level change only after STABLE consecutive synchronized samples
// of the new level. Aborted transitions are tallied in a saturating 8-bit
// glitch counter. Legal STABLE range is 2..255.
module input_conditioner #(
   parameter int unsigned STABLE = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       en,
   input  logic       raw_in,
   input  logic       glitch_clr,
   output logic       out,
   output logic       rise,
   output logic       fall,
   output logic [7:0] glitch_cnt
);

   typedef enum logic [1:0] {
      LOW      = 2'd0,
      LOW2HIGH = 2'd1,
      HIGH     = 2'd2,
      HIGH2LOW = 2'd3
   } state_e;

   // Sample count at which the next confirming sample commits the change.
   localparam logic [7:0] CNT_LAST = 8'(STABLE - 1);

   logic [1:0] sync_q, sync_d;
   logic       s;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   logic       out_q, out_d;
   logic       rise_q, rise_d;
   logic       fall_q, fall_d;
   logic [7:0] glitch_cnt_q, glitch_cnt_d;

   logic       commit;
   logic       abort;

   // Synchronizer shift path; runs regardless of en.
   always_comb begin
      sync_d = {sync_q[0], raw_in};
   end

   assign s = sync_q[1];

   // Synchronizer flops.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   // FSM state and sample-counter register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= LOW;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; with en low everything holds, freezing any pending
   // transition together with its sample count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      abort   = 1'b0;
      if (en) begin
         case (state_q)
            LOW: begin
               if (s) begin
                  state_d = LOW2HIGH;
                  cnt_d   = 8'd1;
               end
            end
            LOW2HIGH: begin
               if (s) begin
                  if (cnt_q == CNT_LAST) begin
                     state_d = HIGH;
                     cnt_d   = '0;
                     commit  = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end else begin
                  state_d = LOW;
                  cnt_d   = '0;
                  abort   = 1'b1;
               end
            end
            HIGH: begin
               if (!s) begin
                  state_d = HIGH2LOW;
                  cnt_d   = 8'd1;
               end
            end
            HIGH2LOW: begin
               if (!s) begin
                  if (cnt_q == CNT_LAST) begin
                     state_d = LOW;
                     cnt_d   = '0;
                     commit  = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end else begin
                  state_d = HIGH;
                  cnt_d   = '0;
                  abort   = 1'b1;
               end
            end
            default: begin
               state_d = LOW;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Output logic: level and edge pulses on commit, saturating glitch count
   // on abort; a clear request overrides a coincident abort.
   always_comb begin
      out_d        = out_q;
      rise_d       = 1'b0;
      fall_d       = 1'b0;
      glitch_cnt_d = glitch_cnt_q;
      if (commit) begin
         out_d  = (state_q == LOW2HIGH);
         rise_d = (state_q == LOW2HIGH);
         fall_d = (state_q == HIGH2LOW);
      end
      if (abort && (glitch_cnt_q != 8'hFF)) begin
         glitch_cnt_d = glitch_cnt_q + 8'd1;
      end
      if (glitch_clr) begin
         glitch_cnt_d = '0;
      end
   end

   // Registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_q        <= 1'b0;
         rise_q       <= 1'b0;
         fall_q       <= 1'b0;
         glitch_cnt_q <= '0;
      end else begin
         out_q        <= out_d;
         rise_q       <= rise_d;
         fall_q       <= fall_d;
         glitch_cnt_q <= glitch_cnt_d;
      end
   end

   assign out        = out_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios followed by randomized
// stimulus, all checked against a run-length reference model.
module tb_input_conditioner;

   localparam int STABLE = 4;

   logic       clock;
   logic       reset;
   logic       en;
   logic       raw_in;
   logic       glitch_clr;
   logic       out;
   logic       rise;
   logic       fall;
   logic [7:0] glitch_cnt;

   input_conditioner #(.STABLE(STABLE)) dut (
      .clock      (clock),
      .reset      (reset),
      .en         (en),
      .raw_in     (raw_in),
      .glitch_clr (glitch_clr),
      .out        (out),
      .rise       (rise),
      .fall       (fall),
      .glitch_cnt (glitch_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: two-stage sample pipeline, committed level, and the
   // length of the current run of enabled samples disagreeing with it.
   bit    m_s1, m_s;
   bit    m_out, m_rise, m_fall;
   int    m_run;
   int    m_glitch;

   int    n_pass   = 0;
   int    n_checks = 0;
   string phase    = "init";

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
   endtask

   task automatic model_clear();
      m_s1 = 0; m_s = 0; m_out = 0; m_rise = 0; m_fall = 0;
      m_run = 0; m_glitch = 0;
   endtask

   task automatic model_edge();
      m_rise = 0;
      m_fall = 0;
      if (en) begin
         if (m_s != m_out) begin
            m_run = m_run + 1;
            if (m_run == STABLE) begin
               m_out  = !m_out;
               m_rise = m_out;
               m_fall = !m_out;
               m_run  = 0;
            end
         end else begin
            if (m_run > 0 && m_glitch < 255) m_glitch = m_glitch + 1;
            m_run = 0;
         end
      end
      if (glitch_clr) m_glitch = 0;
      m_s  = m_s1;
      m_s1 = raw_in;
   endtask

   task automatic compare_all();
      check("out", {7'd0, out}, {7'd0, m_out});
      check("rise", {7'd0, rise}, {7'd0, m_rise});
      check("fall", {7'd0, fall}, {7'd0, m_fall});
      check("glitch_cnt", glitch_cnt, 8'(m_glitch));
      check("rise_and_fall", {7'd0, rise & fall}, 8'd0);
   endtask

   // One clock: inputs already applied, sample outputs 1 time unit later.
   task automatic tick();
      @(posedge clock);
      if (!reset) model_clear();
      else        model_edge();
      #1;
      compare_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Asynchronous reset pulse placed mid-cycle, checked while asserted.
   task automatic async_reset();
      #2 reset = 1'b0;
      #1 model_clear();
      compare_all();
      #1 reset = 1'b1;
   endtask

   initial begin
      int hold;

      // Reset with raw_in=1, en=1: outputs stay cleared throughout.
      phase      = "reset_hold";
      reset      = 1'b0;
      en         = 1'b1;
      raw_in     = 1'b1;
      glitch_clr = 1'b0;
      #1 model_clear();
      compare_all();
      ticks(3);

      // Release with raw_in held high: normal commit on the 6th edge.
      phase = "post_reset_rise";
      reset = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 5) check("out_before_6th", {7'd0, out}, 8'd0);
      end
      check("out_6th", {7'd0, out}, 8'd1);
      check("rise_6th", {7'd0, rise}, 8'd1);
      tick();
      check("rise_one_cycle", {7'd0, rise}, 8'd0);

      // Basic 0->1 latency.
      phase  = "latency";
      raw_in = 1'b0;
      ticks(8);
      raw_in = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 5) check("out_before_6th", {7'd0, out}, 8'd0);
      end
      check("out_6th", {7'd0, out}, 8'd1);
      check("rise_6th", {7'd0, rise}, 8'd1);
      check("glitch_zero", glitch_cnt, 8'd0);
      tick();
      check("rise_one_cycle", {7'd0, rise}, 8'd0);

      // Short pulses abort; glitch count saturates at 255.
      phase  = "glitch";
      raw_in = 1'b0;
      ticks(8);
      for (int k = 0; k < 300; k++) begin
         raw_in = 1'b1;
         ticks(2);
         raw_in = 1'b0;
         ticks(4);
         if (k == 0) begin
            check("first_glitch", glitch_cnt, 8'd1);
            check("out_low", {7'd0, out}, 8'd0);
         end
      end
      check("saturated", glitch_cnt, 8'd255);

      // Clear coinciding with an abort: clear wins.
      phase  = "clr_vs_abort";
      raw_in = 1'b1;
      ticks(2);
      raw_in = 1'b0;
      ticks(2);
      glitch_clr = 1'b1;
      tick();
      check("cleared", glitch_cnt, 8'd0);
      glitch_clr = 1'b0;
      tick();

      // Freeze a pending fall with en low, then resume.
      phase  = "freeze";
      raw_in = 1'b1;
      ticks(8);
      raw_in = 1'b0;
      ticks(4);
      en = 1'b0;
      ticks(5);
      check("held_high", {7'd0, out}, 8'd1);
      en = 1'b1;
      tick();
      check("resume_1", {7'd0, out}, 8'd1);
      tick();
      check("resume_2_out", {7'd0, out}, 8'd0);
      check("resume_2_fall", {7'd0, fall}, 8'd1);
      check("glitch_same", glitch_cnt, 8'd0);
      ticks(2);

      // Reset mid LOW2HIGH (cnt=2) discards the transition.
      phase  = "reset_mid";
      raw_in = 1'b1;
      ticks(4);
      async_reset();
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 5) check("out_before_6th", {7'd0, out}, 8'd0);
      end
      check("out_6th", {7'd0, out}, 8'd1);
      check("rise_6th", {7'd0, rise}, 8'd1);

      // Randomized runs of raw_in with sporadic en, clear and reset.
      phase = "random";
      for (int k = 0; k < 400; k++) begin
         raw_in = 1'($urandom_range(0, 1));
         hold   = int'($urandom_range(1, 8));
         for (int j = 0; j < hold; j++) begin
            en         = ($urandom_range(0, 9) != 0);
            glitch_clr = ($urandom_range(0, 49) == 0);
            tick();
         end
         if ($urandom_range(0, 99) == 0) async_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter STABLE, default 4, meaning the number of consecutive synchronized samples required to accept a level change; legal range is 2..255.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit: conditioning enable.
REQ-005 The block SHALL have port raw_in, input, 1 bit: raw asynchronous serial input.
REQ-006 The block SHALL have port glitch_clr, input, 1 bit: synchronous clear of glitch_cnt.
REQ-007 The block SHALL have port out, output, 1 bit: debounced level, which drives the downstream FSM serial input "in".
REQ-008 The block SHALL have port rise, output, 1 bit: one-cycle pulse when out goes 0->1.
REQ-009 The block SHALL have port fall, output, 1 bit: one-cycle pulse when out goes 1->0.
REQ-010 The block SHALL have port glitch_cnt, output, 8 bits: saturating count of aborted transitions.

Function
REQ-011 The block SHALL pass raw_in through a 2-flop synchronizer producing s; the synchronizer SHALL run regardless of en.
REQ-012 The block SHALL implement a state machine with states LOW, LOW2HIGH, HIGH and HIGH2LOW, plus an 8-bit sample counter cnt.
REQ-013 In LOW with en=1 and s=1, the state SHALL go to LOW2HIGH with cnt=1; with s=0, it SHALL stay in LOW.
REQ-014 In LOW2HIGH with en=1 and s=1: if cnt==STABLE-1, the state SHALL go to HIGH, set out=1, and pulse rise for 1 cycle; otherwise cnt SHALL be incremented.
REQ-015 In LOW2HIGH with en=1 and s=0, the state SHALL return to LOW, cnt SHALL be cleared, and glitch_cnt SHALL be incremented; out SHALL stay 0 and no rise pulse SHALL occur.
REQ-016 HIGH and HIGH2LOW SHALL mirror REQ-013..015 with s inverted: a committed change sets out=0 and pulses fall; an aborted change returns to HIGH and increments glitch_cnt.
REQ-017 Latency SHALL be as follows: out changes on the (STABLE+2)th rising edge, counting the first edge that samples the new raw_in level, provided raw_in is held stable; with STABLE=4 this is the 6th edge.
REQ-018 out, rise and fall SHALL be registered outputs; rise/fall SHALL coincide with the edge at which out changes and SHALL never both be 1.
REQ-019 With en=0, the state, cnt, out and glitch_cnt SHALL hold (a pending transition is frozen, not aborted), and rise=fall=0; on return to en=1, evaluation SHALL resume from the held state and cnt.
REQ-020 glitch_cnt SHALL saturate at 255; further aborts SHALL leave it at 255.
REQ-021 glitch_clr=1 SHALL set glitch_cnt to 0 on the next edge, independent of en; if glitch_clr coincides with an abort, the clear SHALL win (result 0).
REQ-022 A raw_in pulse shorter than STABLE synchronized samples SHALL never change out.

Reset
REQ-023 reset=0 SHALL immediately force: state LOW, cnt 0, synchronizer flops 0, out 0, rise 0, fall 0, glitch_cnt 0.
REQ-024 Reset asserted mid-transition (LOW2HIGH or HIGH2LOW) SHALL discard the transition without a rise/fall pulse or a glitch count.
REQ-025 After reset release with raw_in=1 held, the block SHALL perform a normal LOW->HIGH commit per REQ-017, including a rise pulse.

Verification
REQ-026 The bench SHALL cover: reset=0 with raw_in=1, en=1 -> out=0, rise=0, glitch_cnt=0 throughout reset.
REQ-027 The bench SHALL cover: STABLE=4, en=1, raw_in 0->1 held -> out=1 on the 6th edge, rise=1 for exactly that one cycle, glitch_cnt=0.
REQ-028 The bench SHALL cover: raw_in high for 2 cycles, then low -> out stays 0, no rise pulse, glitch_cnt=1; repeat 300 times -> glitch_cnt=255.
REQ-029 The bench SHALL cover: out=1, raw_in 1->0, en dropped to 0 for 5 cycles after the 2nd synchronized low sample, then en=1 -> fall occurs 2 edges after en returns, out=0, glitch_cnt unchanged.
REQ-030 The bench SHALL cover: glitch_clr=1 in the same cycle as an aborted transition -> glitch_cnt=0 on the next edge.
REQ-031 The bench SHALL cover: reset pulsed low during LOW2HIGH (cnt=2) -> out=0, no rise pulse, glitch_cnt=0; with raw_in held 1 after release -> out=1 on the 6th edge after release.
